frame_capture: RTL
==================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter ROW, default 256, image height in pixels.
REQ-002 Parameter COL, default 256, image width in pixels.
REQ-003 Parameter Pixel_Width, default 8, bits per pixel.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port pixel_in  input  Pixel_Width  incoming filtered pixel, raster order.
REQ-007 Port pixel_valid  input  1  pixel_in is valid this cycle.
REQ-008 Port done_in  input  1  upstream filter signals end of frame.
REQ-009 Port clear  input  1  synchronous request to re-arm for the next frame.
REQ-010 Port rd_en  input  1  readback request.
REQ-011 Port rd_addr  input  16  readback address, row*COL+col.
REQ-012 Port rd_data  output  Pixel_Width  readback pixel.
REQ-013 Port rd_valid  output  1  rd_data is valid.
REQ-014 Port wr_count  output  17  number of pixels stored in the current frame.
REQ-015 Port frame_done  output  1  full frame stored; level, held until clear.
REQ-016 Port short_frame  output  1  sticky flag: done_in seen before ROW*COL pixels were stored.
REQ-017 Port overflow  output  1  sticky flag: pixel_valid seen while in FULL.
REQ-018 Port checksum  output  24  running sum of the stored pixels, modulo 2^24.

Function
REQ-019 The FSM SHALL have the states IDLE, CAPTURE and FULL.
REQ-020 In IDLE, a pixel_valid SHALL write pixel_in to address 0, set wr_count to 1 and move the FSM to CAPTURE.
REQ-021 In CAPTURE, each pixel_valid SHALL write to address wr_count and then increment wr_count by 1.
REQ-022 Storing the pixel at address ROW*COL-1 SHALL move the FSM to FULL and assert frame_done on the next cycle.
REQ-023 done_in in CAPTURE with wr_count < ROW*COL SHALL set short_frame and move the FSM to FULL.
REQ-024 done_in and the final pixel_valid in the same cycle SHALL store the pixel and SHALL NOT set short_frame.
REQ-025 pixel_valid in FULL SHALL be ignored (no write) and SHALL set overflow.
REQ-026 clear from any state SHALL return the FSM to IDLE and zero wr_count, frame_done, short_frame, overflow and checksum.
REQ-027 clear has priority over a pixel_valid in the same cycle; that pixel is dropped.
REQ-028 rd_en SHALL produce rd_data = mem[rd_addr] with rd_valid high exactly one cycle later.
REQ-029 Reads SHALL be allowed in every state.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-031 rd_addr >= ROW*COL SHALL return 0, with rd_valid still asserted.
REQ-032 done_in and pixel_valid while in IDLE SHALL NOT be combined: done_in alone in IDLE is ignored.

Reset
REQ-033 Reset low SHALL immediately force the FSM to IDLE and set wr_count, frame_done, short_frame, overflow, checksum, rd_data and rd_valid to 0.
REQ-034 Reset SHALL NOT initialise the memory contents.
REQ-035 Reset asserted mid-frame SHALL abort the capture; the next pixel_valid after release is stored at address 0.

Configuration
REQ-036 The macro FRAME_CAPTURE_CHECKSUM_EN, when defined, SHALL make checksum accumulate pixel_in on every stored write.
REQ-037 When FRAME_CAPTURE_CHECKSUM_EN is undefined, checksum SHALL be tied to 0 and no adder is synthesised.

Structure
REQ-038 A shared package SHALL hold the FSM state typedef (IDLE, CAPTURE, FULL) and the constants for the default ROW, COL, Pixel_Width and the checksum width 24.
REQ-039 The storage SHALL be a sub-module frame_ram: a simple dual-port RAM of ROW*COL x Pixel_Width with one write port and one registered read port.

Verification
REQ-040 4x4 frame, pixels 0..15 streamed back-to-back -> frame_done=1 one cycle after the 16th pixel; wr_count=16; checksum=120; reading address 5 returns 5.
REQ-041 4x4 frame, done_in after 10 pixels -> short_frame=1, FSM in FULL, wr_count=10, frame_done=0.
REQ-042 Full frame, then 1 extra pixel_valid with value 0xAA -> overflow=1; address 0 is unchanged.
REQ-043 Reset pulsed low after 7 pixels, then 16 new pixels 0x10..0x1F -> address 0 reads 0x10; frame_done=1.
REQ-044 Write of 0x33 to address 3 while reading address 3 (old value 0x03) -> rd_data=0x03 that cycle and 0x33 on the next read.
REQ-045 clear and pixel_valid in the same cycle while in FULL -> FSM in IDLE, all flags 0, pixel not stored.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// Shared types and default sizing for the frame capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package frame_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } cap_state_t;

    localparam int DEF_ROW         = 256;
    localparam int DEF_COL         = 256;
    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int CHECKSUM_W      = 24;
    localparam int COUNT_W         = 17;
    localparam int ADDR_W          = 16;

    // Index width needed to address a RAM of the given depth (never below 1).
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Latency: read data and rd_valid appear one cycle after rd_en; same-address write returns old data.
// Backpressure: none; every read and write is accepted in the cycle it is presented.
module frame_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_oob,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array: deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sampling mem before the write lands gives read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_oob ? '0 : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/frame_capture.sv
// Captures one raster-order frame into RAM with status flags; optional checksum under FRAME_CAPTURE_CHECKSUM_EN.
// Latency: pixel written on the cycle it is valid; status flags and readback update one cycle later.
// Backpressure: none; pixels arriving once the frame is closed are dropped and flagged as overflow.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int ROW         = DEF_ROW,
    parameter int COL         = DEF_COL,
    parameter int Pixel_Width = DEF_PIXEL_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Pixel_Width-1:0] pixel_in,
    input  logic                   pixel_valid,
    input  logic                   done_in,
    input  logic                   clear,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [Pixel_Width-1:0] rd_data,
    output logic                   rd_valid,
    output logic [COUNT_W-1:0]     wr_count,
    output logic                   frame_done,
    output logic                   short_frame,
    output logic                   overflow,
    output logic [CHECKSUM_W-1:0]  checksum
);

    localparam int                 DEPTH     = ROW * COL;
    localparam int                 IW        = addr_bits(DEPTH);
    localparam logic [COUNT_W-1:0] DEPTH_W   = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] LAST_ADDR = COUNT_W'(DEPTH - 1);

    cap_state_t         state_q, state_d;
    logic [COUNT_W-1:0] count_d;
    logic               done_d, short_d, ovf_d;
    logic               wr_en;
    logic               last_px;
    logic               rd_oob;

    // The incoming pixel is the one that completes the frame.
    assign last_px = (wr_count == LAST_ADDR);
    assign rd_oob  = ({1'b0, rd_addr} >= DEPTH_W);

    // State and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_count    <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count    <= count_d;
            frame_done  <= done_d;
            short_frame <= short_d;
            overflow    <= ovf_d;
        end
    end

    // Next state, write strobe and flag updates; clear overrides everything.
    always_comb begin
        state_d = state_q;
        count_d = wr_count;
        done_d  = frame_done;
        short_d = short_frame;
        ovf_d   = overflow;
        wr_en   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
            short_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // done_in has no meaning before the first pixel arrives.
                    if (pixel_valid) begin
                        wr_en   = 1'b1;
                        count_d = 17'd1;
                        state_d = CAPTURE;
                        if (last_px) begin
                            state_d = FULL;
                            done_d  = 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (pixel_valid) begin
                        wr_en   = 1'b1;
                        count_d = wr_count + 17'd1;
                    end
                    if (pixel_valid && last_px) begin
                        state_d = FULL;
                        done_d  = 1'b1;
                    end else if (done_in) begin
                        state_d = FULL;
                        short_d = 1'b1;
                    end
                end
                FULL: begin
                    if (pixel_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] sum_q;

    // Running sum of every pixel that actually lands in the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (wr_en) begin
            sum_q <= sum_q + CHECKSUM_W'(pixel_in);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    frame_ram #(
        .DEPTH (DEPTH),
        .AW    (IW),
        .DW    (Pixel_Width)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_count[IW-1:0]),
        .wr_data  (pixel_in),
        .rd_en    (rd_en),
        .rd_oob   (rd_oob),
        .rd_addr  (rd_addr[IW-1:0]),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule
